// File: rtl/dlx_data_memory.sv
// Data-side memory responder for the uDLX core.
// Word-addressed on-chip RAM plus a four-register MMIO page (GPIO out, synchronized
// GPIO in, free-running cycle counter, sticky error status). Read data is registered
// with a fixed one-cycle latency and the block never stalls the core.
module dlx_data_memory #(
    parameter int unsigned                 DATA_WIDTH      = 32,
    parameter int unsigned                 DATA_ADDR_WIDTH = 32,
    parameter int unsigned                 MEM_DEPTH_LOG2  = 10,
    parameter logic [DATA_ADDR_WIDTH-1:0]  MMIO_BASE       = 32'hFFFF_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_rd_en,
    input  logic                       data_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_write,
    output logic [DATA_WIDTH-1:0]      data_read,
    input  logic [DATA_WIDTH-1:0]      gpio_in,
    output logic [DATA_WIDTH-1:0]      gpio_out,
    output logic                       err_out,
    output logic [DATA_ADDR_WIDTH-1:0] err_addr_out
);

    localparam int unsigned MEM_DEPTH    = 1 << MEM_DEPTH_LOG2;
    localparam logic [15:0] REG_GPIO_OUT = 16'h0000;
    localparam logic [15:0] REG_GPIO_IN  = 16'h0004;
    localparam logic [15:0] REG_CYCLE    = 16'h0008;
    localparam logic [15:0] REG_ERR      = 16'h000C;

    logic [DATA_WIDTH-1:0]     mem_r [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0]     gpio_sync1_r;
    logic [DATA_WIDTH-1:0]     gpio_sync2_r;
    logic [DATA_WIDTH-1:0]     cycle_cnt_r;
    logic                      err_mis_r;

    logic                      access_s;
    logic                      misaligned_s;
    logic                      ram_hit_s;
    logic                      mmio_hit_s;
    logic                      reg_known_s;
    logic                      err_s;
    logic                      ok_s;
    logic                      ram_wr_s;
    logic                      reg_wr_s;
    logic                      gpio_wr_s;
    logic                      cnt_wr_s;
    logic                      err_clr_s;
    logic [15:0]               offset_s;
    logic [MEM_DEPTH_LOG2-1:0] word_idx_s;
    logic [DATA_WIDTH-1:0]     rd_data_s;

    // Address decode: classify the access and derive the qualified write strobes.
    always_comb begin
        access_s     = data_rd_en | data_wr_en;
        misaligned_s = (data_addr[1:0] != 2'b00);
        ram_hit_s    = ((data_addr >> (MEM_DEPTH_LOG2 + 2)) == {DATA_ADDR_WIDTH{1'b0}});
        mmio_hit_s   = (data_addr[DATA_ADDR_WIDTH-1:16] == MMIO_BASE[DATA_ADDR_WIDTH-1:16]);
        offset_s     = data_addr[15:0];
        word_idx_s   = data_addr[MEM_DEPTH_LOG2+1:2];
        case (offset_s)
            REG_GPIO_OUT, REG_GPIO_IN, REG_CYCLE, REG_ERR: reg_known_s = 1'b1;
            default:                                       reg_known_s = 1'b0;
        endcase
        // Misalignment and unmapped addresses both drop the access.
        err_s     = access_s & (misaligned_s | ~(ram_hit_s | (mmio_hit_s & reg_known_s)));
        ok_s      = access_s & ~err_s;
        ram_wr_s  = data_wr_en & ok_s & ram_hit_s;
        reg_wr_s  = data_wr_en & ok_s & mmio_hit_s;
        gpio_wr_s = reg_wr_s & (offset_s == REG_GPIO_OUT);
        cnt_wr_s  = reg_wr_s & (offset_s == REG_CYCLE);
        err_clr_s = reg_wr_s & (offset_s == REG_ERR) & data_write[0];
    end

    // Read mux: RAM word or register page value as seen before this edge.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        if (ram_hit_s) begin
            rd_data_s = mem_r[word_idx_s];
        end else begin
            case (offset_s)
                REG_GPIO_OUT: rd_data_s = gpio_out;
                REG_GPIO_IN:  rd_data_s = gpio_sync2_r;
                REG_CYCLE:    rd_data_s = cycle_cnt_r;
                REG_ERR:      rd_data_s = {{(DATA_WIDTH-2){1'b0}}, err_mis_r, err_out};
                default:      rd_data_s = {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // RAM write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            mem_r[word_idx_s] <= data_write;
        end
    end

    // Registered read data: dropped reads return zero, idle cycles hold the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_read <= {DATA_WIDTH{1'b0}};
        end else if (data_rd_en) begin
            data_read <= ok_s ? rd_data_s : {DATA_WIDTH{1'b0}};
        end else begin
            data_read <= data_read;
        end
    end

    // GPIO output register and two-flop input synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out     <= {DATA_WIDTH{1'b0}};
            gpio_sync1_r <= {DATA_WIDTH{1'b0}};
            gpio_sync2_r <= {DATA_WIDTH{1'b0}};
        end else begin
            gpio_out     <= gpio_wr_s ? data_write : gpio_out;
            gpio_sync1_r <= gpio_in;
            gpio_sync2_r <= gpio_sync1_r;
        end
    end

    // Free-running cycle counter; any write reloads it to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_r <= {DATA_WIDTH{1'b0}};
        end else if (cnt_wr_s) begin
            cycle_cnt_r <= {DATA_WIDTH{1'b0}};
        end else begin
            cycle_cnt_r <= cycle_cnt_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Sticky error status: a clear beats a simultaneous error; the first error address wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_out      <= 1'b0;
            err_mis_r    <= 1'b0;
            err_addr_out <= {DATA_ADDR_WIDTH{1'b0}};
        end else if (err_clr_s) begin
            err_out      <= 1'b0;
            err_mis_r    <= 1'b0;
            err_addr_out <= {DATA_ADDR_WIDTH{1'b0}};
        end else if (err_s) begin
            err_out      <= 1'b1;
            err_mis_r    <= misaligned_s;
            err_addr_out <= err_out ? err_addr_out : data_addr;
        end else begin
            err_out      <= err_out;
            err_mis_r    <= err_mis_r;
            err_addr_out <= err_addr_out;
        end
    end

endmodule

// File: tb/tb_dlx_data_memory.sv
// Self-checking bench for dlx_data_memory: read expectations are queued when a read
// is driven and compared after the edge that produces data_read.
module tb_dlx_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        err_out;
    logic [31:0] err_addr_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    dlx_data_memory dut (
        .clk          (clk),
        .rst          (rst),
        .data_rd_en   (data_rd_en),
        .data_wr_en   (data_wr_en),
        .data_addr    (data_addr),
        .data_write   (data_write),
        .data_read    (data_read),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .err_out      (err_out),
        .err_addr_out (err_addr_out)
    );

    always #5 clk = ~clk;

    // Drive one request on the falling edge, return 1 time unit after the next rising edge.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        data_rd_en = rd;
        data_wr_en = wr;
        data_addr  = addr;
        data_write = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_rd_en = 1'b0; data_wr_en = 1'b0;
        data_addr = 32'h0; data_write = 32'h0; gpio_in = 32'h0;
        #3;
        checks++; if (data_read !== 32'h0) begin errors++; $display("FAIL reset_data_read got %h exp %h", data_read, 32'h0); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio_out got %h exp %h", gpio_out, 32'h0); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err_out got %b exp 0", err_out); end
        checks++; if (err_addr_out !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h exp %h", err_addr_out, 32'h0); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic_rw();
        drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL rd_0x10 got %h exp %h", data_read, exp_v); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            checks++; if (data_read !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_%0d got %h exp %h", i, data_read, 32'hDEAD_BEEF); end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 32'h0,   32'h1111_1111);
        drive(1'b0, 1'b1, 32'hFFC, 32'h2222_2222);
        exp_q.push_back(32'h1111_1111);
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL b2b_rd_0x0 got %h exp %h", data_read, exp_v); end
        exp_q.push_back(32'h2222_2222);
        drive(1'b1, 1'b0, 32'hFFC, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL b2b_rd_0xffc got %h exp %h", data_read, exp_v); end
    endtask

    task automatic test_read_before_write();
        drive(1'b0, 1'b1, 32'h20, 32'h5);
        exp_q.push_back(32'h5);
        drive(1'b1, 1'b1, 32'h20, 32'h9);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL rbw_old got %h exp %h", data_read, exp_v); end
        exp_q.push_back(32'h9);
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL rbw_new got %h exp %h", data_read, exp_v); end
    endtask

    task automatic test_errors();
        drive(1'b0, 1'b1, 32'h4, 32'h1234_5678);
        exp_q.push_back(32'h0);
        drive(1'b1, 1'b0, 32'h1000, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL oob_read got %h exp %h", data_read, exp_v); end
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL oob_err_out got %b exp 1", err_out); end
        checks++; if (err_addr_out !== 32'h1000) begin errors++; $display("FAIL oob_err_addr got %h exp %h", err_addr_out, 32'h1000); end
        drive(1'b0, 1'b1, 32'h6, 32'hFFFF_FFFF);
        checks++; if (err_addr_out !== 32'h1000) begin errors++; $display("FAIL first_err_wins got %h exp %h", err_addr_out, 32'h1000); end
        exp_q.push_back(32'h3);
        drive(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL err_status_mis got %h exp %h", data_read, exp_v); end
        exp_q.push_back(32'h1234_5678);
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL dropped_write got %h exp %h", data_read, exp_v); end
        drive(1'b0, 1'b1, 32'hFFFF_000C, 32'h1);
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL clear_err_out got %b exp 0", err_out); end
        checks++; if (err_addr_out !== 32'h0) begin errors++; $display("FAIL clear_err_addr got %h exp %h", err_addr_out, 32'h0); end
        exp_q.push_back(32'h0);
        drive(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL err_status_clr got %h exp %h", data_read, exp_v); end
        exp_q.push_back(32'h0);
        drive(1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL bad_offset_read got %h exp %h", data_read, exp_v); end
        checks++; if (err_addr_out !== 32'hFFFF_0010) begin errors++; $display("FAIL bad_offset_addr got %h exp %h", err_addr_out, 32'hFFFF_0010); end
        exp_q.push_back(32'h1);
        drive(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL err_status_aligned got %h exp %h", data_read, exp_v); end
        drive(1'b0, 1'b1, 32'hFFFF_000C, 32'h1);
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL clear2_err_out got %b exp 0", err_out); end
    endtask

    task automatic test_gpio();
        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'hA5);
        checks++; if (gpio_out !== 32'hA5) begin errors++; $display("FAIL gpio_out got %h exp %h", gpio_out, 32'hA5); end
        exp_q.push_back(32'hA5);
        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL gpio_out_rd got %h exp %h", data_read, exp_v); end
        gpio_in = 32'h3C;
        exp_q.push_back(32'h0);
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL gpio_in_edge1 got %h exp %h", data_read, exp_v); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h3C);
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL gpio_in_edge3 got %h exp %h", data_read, exp_v); end
        drive(1'b0, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF);
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL gpio_in_write_err got %b exp 0", err_out); end
    endtask

    task automatic test_cycle_cnt_and_reset();
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h1234);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back(32'h4);
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL cycle_cnt got %h exp %h", data_read, exp_v); end
        exp_q.push_back(32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL pre_rst_read got %h exp %h", data_read, exp_v); end
        #2 rst = 1'b1;
        #1;
        checks++; if (data_read !== 32'h0) begin errors++; $display("FAIL async_rst_read got %h exp %h", data_read, 32'h0); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL async_rst_gpio got %h exp %h", gpio_out, 32'h0); end
        @(negedge clk);
        rst = 1'b0; data_rd_en = 1'b0; data_wr_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (data_read !== 32'h0) begin errors++; $display("FAIL post_rst_stale got %h exp %h", data_read, 32'h0); end
        exp_q.push_back(32'h1);
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        exp_v = exp_q.pop_front();
        checks++; if (data_read !== exp_v) begin errors++; $display("FAIL post_rst_cnt got %h exp %h", data_read, exp_v); end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_back_to_back();
        test_read_before_write();
        test_errors();
        test_gpio();
        test_cycle_cnt_and_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_data_memory.md
# dlx_data_memory

Data-side memory responder for the uDLX core: the target that answers the processor's data memory port (`data_rd_en`, `data_wr_en`, `data_addr`, `data_write`, `data_read`). It holds a word-addressed on-chip data RAM plus a small memory-mapped register page (GPIO, cycle counter, error status). Read data is returned with fixed one-cycle latency, matching the core's MEM→WB timing. The core has no data-side stall, so the block never back-pressures.

## Interface
- `DATA_WIDTH`, 32, data word width
- `DATA_ADDR_WIDTH`, 32, byte address width
- `MEM_DEPTH_LOG2`, 10, log2 of RAM depth in words (default 1024 words = 4 KiB)
- `MMIO_BASE`, 32'hFFFF_0000, base byte address of the register page (upper 16 bits decoded)
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `data_rd_en`  in  1  read request, sampled each edge
- `data_wr_en`  in  1  write request, sampled each edge
- `data_addr`  in  DATA_ADDR_WIDTH  byte address
- `data_write`  in  DATA_WIDTH  write data
- `data_read`  out  DATA_WIDTH  registered read data
- `gpio_in`  in  DATA_WIDTH  asynchronous external inputs
- `gpio_out`  out  DATA_WIDTH  registered GPIO output
- `err_out`  out  1  sticky access-error flag
- `err_addr_out`  out  DATA_ADDR_WIDTH  address of first error since last clear

## Operation
- Decode per access (`data_rd_en | data_wr_en`):
  - misaligned (`data_addr[1:0] != 0`) → error, access dropped
  - RAM: `data_addr < 4 << MEM_DEPTH_LOG2`; word index `data_addr[MEM_DEPTH_LOG2+1:2]`
  - MMIO: `data_addr[31:16] == MMIO_BASE[31:16]`; offset `data_addr[15:0]`
  - anything else → error, access dropped
- Register page:
  - 0x0 GPIO_OUT: RW; drives `gpio_out`
  - 0x4 GPIO_IN: RO; value of 2-flop synchronizer on `gpio_in`; writes ignored, no error
  - 0x8 CYCLE_CNT: free-running 32-bit counter, +1 per edge, wraps 0xFFFF_FFFF→0; any write loads 0 at that edge
  - 0xC ERR_STATUS: bit0 = sticky error, bit1 = last error was misaligned, other bits 0; write with bit0=1 clears both bits and `err_addr_out`
  - other offsets in page → error
- Error: sets `err_out`; `err_addr_out` captures `data_addr` only if `err_out` was 0 (first error wins). An error on the same edge as an ERR_STATUS clear is lost; the clear wins.
- Dropped reads return 0 on `data_read`; dropped writes change nothing.
- `rd_en` and `wr_en` together: write performed; read returns the pre-write value (read-before-write).
- RAM contents are not reset. The bench must write before reading.

## Timing
- Reset (async, immediate): `data_read`=0, `gpio_out`=0, CYCLE_CNT=0, `err_out`=0, `err_addr_out`=0, synchronizer flops=0. Any in-flight read is discarded.
- Read: request sampled at edge N; `data_read` valid from N until edge N+1 updates it. Latency is 1 cycle.
- `data_read` holds its last value when no read is sampled.
- Write: RAM/register updated at the sampling edge. A read at the next edge returns the new value; no bypass is needed.
- CYCLE_CNT read returns the pre-edge value.
- A `gpio_in` change is visible to a read sampled 2 edges later (3rd edge after change, worst case).
- `err_out` and `err_addr_out` update at the edge of the offending access.

## Test plan
- Reset, then write 0xDEAD_BEEF at 0x0000_0010; read 0x10 next cycle → `data_read`=0xDEAD_BEEF one cycle after the read edge, held through 3 idle cycles.
- Back-to-back writes to 0x0 and 0xFFC (last word), then back-to-back reads → 1-cycle latency, correct data each cycle, no aliasing between the two words.
- Write 5, then rd+wr 9 same cycle to 0x20 → `data_read`=5; subsequent read → 9.
- Read 0x0000_1000 (just past RAM) → `data_read`=0, `err_out`=1, `err_addr_out`=0x1000. Then misaligned write to 0x6 → `err_addr_out` stays 0x1000, ERR_STATUS reads 0x3. Write 0x1 to 0xFFFF_000C → ERR_STATUS=0, `err_out`=0.
- Write 0xA5 to 0xFFFF_0000 → `gpio_out`=0xA5 after the edge. Set `gpio_in`=0x3C; read GPIO_IN at the 1st edge → old value, at the 3rd edge → 0x3C.
- Write to CYCLE_CNT, idle 4 edges, read → 4. Assert `rst` mid-read → `data_read`=0 immediately; no stale data after release.
